// File: rtl/bit_changer_ctrl.sv
// bit_changer_ctrl: load/edit/done sequencer driving a bit-changer register; define BIT_CHANGER_BOUNDS_CHECK_EN to reject edits with editIdx >= N
module bit_changer_ctrl #(
  parameter int N = 25
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      abort,
  input  logic [N-1:0]              wordIn,
  input  logic                      editValid,
  input  logic [$clog2(N)-1:0]      editIdx,
  input  logic                      editVal,
  input  logic                      editLast,
  output logic                      editReady,
  output logic                      ld,
  output logic                      clr,
  output logic                      en,
  output logic [$clog2(N)-1:0]      bitSelect,
  output logic                      bitChange,
  output logic [N-1:0]              dataOut,
  output logic                      busy,
  output logic                      done,
  output logic [$clog2(N):0]        editCount,
  output logic                      err
);
  localparam int Bits = $clog2(N);
  typedef enum logic [1:0] {IDLE, LOAD, EDIT, DONE} state_t;
  state_t         state_q, state_d;
  logic [N-1:0]   word_q, word_d;
  logic [Bits:0]  cnt_q, cnt_d;
  logic           err_q, err_d;
  logic           acc, oob, go;
`ifdef BIT_CHANGER_BOUNDS_CHECK_EN
  assign oob = {1'b0, editIdx} >= (Bits+1)'(N);
`else
  assign oob = 1'b0;
`endif
  assign go = state_q == IDLE && start;
  // state register
  always_ff @(posedge clk or posedge rst)
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  // next state: abort returns any active state to IDLE; a last accepted edit finishes the job
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: state_d = start ? LOAD : IDLE;
      LOAD: state_d = abort ? IDLE : EDIT;
      EDIT: state_d = abort ? IDLE : (acc && editLast) ? DONE : EDIT;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  // outputs: abort masks every strobe except clr, so ld/clr/en never coincide
  always_comb begin
    busy      = state_q != IDLE;
    editReady = state_q == EDIT && !abort;
    acc       = editReady && editValid;
    en        = acc && !oob;
    ld        = state_q == LOAD && !abort;
    clr       = busy && abort;
    done      = state_q == DONE && !abort;
    bitSelect = en ? editIdx : '0;
    bitChange = en && editVal;
    dataOut   = word_q;
    editCount = cnt_q;
    err       = err_q;
  end
  // job data: captured word, saturating edit counter, sticky range error
  always_comb begin
    word_d = go ? wordIn : word_q;
    cnt_d  = go ? '0 : (en && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;
    err_d  = go ? 1'b0 : (acc && oob) ? 1'b1 : err_q;
  end
  // job data registers
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      word_q <= '0;
      cnt_q  <= '0;
      err_q  <= 1'b0;
    end else begin
      word_q <= word_d;
      cnt_q  <= cnt_d;
      err_q  <= err_d;
    end
endmodule
